// File: rtl/wb_stage_regfile_if.sv
// MEM/WB latch outputs consumed by the write-back stage.
// The MEM/WB register drives this bundle; the WB stage samples it.
interface wb_stage_regfile_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] mem_read_data_in;
    logic [XLEN-1:0] alu_result_in;
    logic [XLEN-1:0] pc_plus4_in;
    logic [XLEN-1:0] imm_in;
    logic [4:0]      rd_in;
    logic            reg_write_in;
    logic            mem_to_reg_in;
    logic            jal_in;
    logic            jalr_in;
    logic            is_lui_in;
    logic            retire_in;

    modport master (
        output mem_read_data_in, alu_result_in, pc_plus4_in, imm_in, rd_in,
        output reg_write_in, mem_to_reg_in, jal_in, jalr_in, is_lui_in, retire_in
    );

    modport slave (
        input mem_read_data_in, alu_result_in, pc_plus4_in, imm_in, rd_in,
        input reg_write_in, mem_to_reg_in, jal_in, jalr_in, is_lui_in, retire_in
    );
endinterface

// File: rtl/wb_stage_regfile.sv
// Write-back stage: selects the WB value, commits it to the integer register file,
// serves two bypassed ID read ports and counts retired instructions.
module wb_stage_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    wb_stage_regfile_if.slave         wb_bus,
    input  logic [4:0]                rs1_addr,
    input  logic [4:0]                rs2_addr,
    output logic [XLEN-1:0]           rs1_data,
    output logic [XLEN-1:0]           rs2_data,
    output logic                      wb_fwd_valid,
    output logic [4:0]                wb_fwd_rd,
    output logic [XLEN-1:0]           wb_fwd_data,
    output logic [CNT_W-1:0]          instret
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [XLEN-1:0]  wb_data;

    always_comb begin
        if (wb_bus.jal_in || wb_bus.jalr_in) begin
            wb_data = wb_bus.pc_plus4_in;
        end else if (wb_bus.is_lui_in) begin
            wb_data = wb_bus.imm_in;
        end else if (wb_bus.mem_to_reg_in) begin
            wb_data = wb_bus.mem_read_data_in;
        end else begin
            wb_data = wb_bus.alu_result_in;
        end
    end

    assign wb_fwd_valid = reset && wb_bus.reg_write_in && (wb_bus.rd_in != 5'd0);
    assign wb_fwd_rd    = wb_bus.rd_in;
    assign wb_fwd_data  = wb_data;

    // Reads return zero while reset is held so the clearing array is never observed.
    always_comb begin
        if (!reset || rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (wb_fwd_valid && rs1_addr == wb_bus.rd_in) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
        if (!reset || rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (wb_fwd_valid && rs2_addr == wb_bus.rd_in) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

    always_comb begin
        instret_d = instret_q;
        if (wb_bus.retire_in) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            instret_q <= '0;
        end else begin
            if (wb_fwd_valid) begin
                regs_q[wb_bus.rd_in] <= wb_data;
            end
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Self-checking bench for wb_stage_regfile: directed cases then random traffic
// against a reference register-file model with a scoreboard of expected reads.
module tb_wb_stage_regfile;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        fwd_valid;
        logic [4:0]  fwd_rd;
        logic [31:0] fwd_data;
        logic [63:0] instret;
        logic        cnt_known;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_fwd_valid;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic [63:0] instret;

    wb_stage_regfile_if #(.XLEN(32)) bus ();

    wb_stage_regfile #(.XLEN(32), .NREGS(32), .CNT_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_bus       (bus.slave),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_fwd_valid (wb_fwd_valid),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_data  (wb_fwd_data),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    logic [31:0] model [32];
    logic [63:0] mcnt;
    logic        cnt_known;
    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Drives one WB transaction just after a posedge, checks at negedge, updates model at posedge.
    task automatic cycle(input logic rst, input logic we, input logic m2r, input logic jal,
                         input logic jalr, input logic lui, input logic ret, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                         input logic [31:0] imm, input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] wbv;
        logic        fv;
        exp_t        e;
        exp_t        got;
        reset = rst;
        bus.reg_write_in = we;  bus.mem_to_reg_in = m2r; bus.jal_in = jal; bus.jalr_in = jalr;
        bus.is_lui_in = lui;    bus.retire_in = ret;     bus.rd_in = rd;
        bus.alu_result_in = alu; bus.mem_read_data_in = mem; bus.pc_plus4_in = pc4;
        bus.imm_in = imm;
        rs1_addr = a1;
        rs2_addr = a2;
        wbv = (jal || jalr) ? pc4 : lui ? imm : m2r ? mem : alu;
        fv  = rst && we && (rd != 5'd0);
        e.rs1 = (!rst || a1 == 5'd0) ? 32'd0 : (fv && a1 == rd) ? wbv : model[a1];
        e.rs2 = (!rst || a2 == 5'd0) ? 32'd0 : (fv && a2 == rd) ? wbv : model[a2];
        e.fwd_valid = fv;
        e.fwd_rd    = rd;
        e.fwd_data  = wbv;
        e.instret   = mcnt;
        e.cnt_known = cnt_known;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        chk("rs1_data", {32'd0, rs1_data}, {32'd0, got.rs1});
        chk("rs2_data", {32'd0, rs2_data}, {32'd0, got.rs2});
        chk("wb_fwd_valid", {63'd0, wb_fwd_valid}, {63'd0, got.fwd_valid});
        chk("wb_fwd_rd", {59'd0, wb_fwd_rd}, {59'd0, got.fwd_rd});
        chk("wb_fwd_data", {32'd0, wb_fwd_data}, {32'd0, got.fwd_data});
        if (got.cnt_known) chk("instret", instret, got.instret);
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            mcnt = 64'd0;
            cnt_known = 1'b1;
        end else begin
            if (fv) model[rd] = wbv;
            if (ret) mcnt = mcnt + 64'd1;
        end
        #1;
    endtask

    task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, a1, a2);
    endtask

    initial begin
        mcnt = 64'd0;
        cnt_known = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two cycles with a write and retire pending on x5.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'd0, 32'd0, 32'd0,
              5'd5, 5'd5);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'd0, 32'd0, 32'd0,
              5'd5, 5'd5);
        idle_read(5'd5, 5'd0);
        chk("x5_after_reset", {32'd0, rs1_data}, 64'd0);
        chk("instret_after_reset", instret, 64'd0);

        // Mux priority.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h11, 32'h22, 32'h104,
              32'h33, 5'd1, 5'd2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h11, 32'h22, 32'h44,
              32'hABCDE000, 5'd1, 5'd2);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h11, 32'hDEADBEEF, 32'h44,
              32'h55, 5'd3, 5'd2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h11, 32'h22, 32'h208,
              32'h55, 5'd4, 5'd1);
        idle_read(5'd1, 5'd2);
        chk("x1_jal", {32'd0, rs1_data}, 64'h104);
        chk("x2_lui", {32'd0, rs2_data}, 64'hABCDE000);
        rs1_addr = 5'd3;
        rs2_addr = 5'd4;
        #1;
        chk("x3_load", {32'd0, rs1_data}, 64'hDEADBEEF);
        chk("x4_jalr", {32'd0, rs2_data}, 64'h208);

        // Same-cycle bypass, then array read.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h55, 32'd0, 32'd0, 32'd0,
              5'd7, 5'd7);
        idle_read(5'd7, 5'd7);
        chk("x7_array", {32'd0, rs2_data}, 64'h55);

        // x0 write discarded.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0,
              5'd0, 5'd0);
        idle_read(5'd0, 5'd7);

        // Retire counting independent of writes.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0,
              5'd0, 5'd0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, (i % 3) != 0 || i == 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'(i + 8),
                  32'(i * 7), 32'd0, 32'd0, 32'd0, 5'(i + 8), 5'd8);
        end
        chk("instret_ten", instret, 64'd10);

        // Counter wrap.
        force dut.instret_q = {64{1'b1}};
        #1;
        release dut.instret_q;
        mcnt = {64{1'b1}};
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0,
              5'd0, 5'd0);
        chk("instret_wrap", instret, 64'd0);

        // Mid-stream reset drops the in-flight write.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 32'd0, 32'd0, 32'd0,
              5'd9, 5'd9);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 32'hAA, 32'd0, 32'd0, 32'd0,
              5'd9, 5'd10);
        idle_read(5'd9, 5'd10);
        chk("x10_dropped", {32'd0, rs2_data}, 64'd0);

        // Random traffic.
        for (int n = 0; n < 10000; n++) begin
            cycle(($urandom_range(63) != 0), 1'($urandom), 1'($urandom), 1'($urandom_range(7) == 0),
                  1'($urandom_range(7) == 0), 1'($urandom_range(3) == 0), 1'($urandom),
                  5'($urandom), $urandom, $urandom, $urandom, $urandom,
                  5'($urandom), 5'($urandom));
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
